// File: rtl/port_trace_monitor.sv
// port_trace_monitor: records value changes on NCH channels into a trace FIFO.
// Each record is a {timestamp, change_mask, data} word. Arming takes a baseline
// snapshot. Running logs every cycle in which a channel differs from its last
// recorded value. The run stops after MAX_CYCLES cycles.
//
// Ports:
//   clk       in   clock; all state changes on its rising edge
//   reset     in   synchronous active-high reset
//   enable    in   arm/run request (level)
//   ch_data   in   NCH*WIDTH monitored values, channel k at [k*WIDTH +: WIDTH]
//   rd_en     in   pop the FIFO head
//   rd_data   out  FIFO head record, first-word-fall-through
//   rd_empty  out  FIFO holds no record
//   full      out  FIFO holds DEPTH records
//   drop_cnt  out  saturating count of records lost to a full FIFO
//   done      out  run-cycle limit reached
//   state     out  FSM state: IDLE=0, ARM=1, RUN=2, DONE=3
module port_trace_monitor #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NCH        = 2,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned TS_W       = 24,
   parameter int unsigned MAX_CYCLES = 500000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [NCH*WIDTH-1:0]            ch_data,
   input  logic                            rd_en,
   output logic [TS_W+NCH+NCH*WIDTH-1:0]   rd_data,
   output logic                            rd_empty,
   output logic                            full,
   output logic [7:0]                      drop_cnt,
   output logic                            done,
   output logic [1:0]                      state
);

   localparam int unsigned DW    = NCH * WIDTH;
   localparam int unsigned REC_W = TS_W + NCH + DW;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = AW + 1;
   localparam logic [TS_W-1:0] TS_LIMIT = TS_W'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_next;
   logic                done_q;
   logic [TS_W-1:0]     ts_q, cur_ts;
   logic [DW-1:0]       prev_q;
   logic [NCH-1:0]      diff_mask, rec_mask;
   logic                push_req, push_ok, pop, drop;

   logic [REC_W-1:0]    mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count_q, count_next;
   logic                empty_q, full_q;
   logic [7:0]          drop_q;

   // Per-channel difference against the last recorded sample.
   always_comb begin
      diff_mask = '0;
      for (int k = 0; k < NCH; k++) begin
         diff_mask[k] = (ch_data[k*WIDTH +: WIDTH] != prev_q[k*WIDTH +: WIDTH]);
      end
   end

   // Next state plus the record that this cycle would push.
   always_comb begin
      state_next = state_q;
      push_req   = 1'b0;
      rec_mask   = '0;
      cur_ts     = ts_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_next = S_ARM;
         end
         S_ARM: begin
            push_req   = 1'b1;
            rec_mask   = '1;
            cur_ts     = '0;
            state_next = S_RUN;
         end
         S_RUN: begin
            // The stamp for this RUN cycle is one past the registered value.
            cur_ts   = ts_q + TS_W'(1);
            rec_mask = diff_mask;
            push_req = |diff_mask;
            if (!enable)                 state_next = S_IDLE;
            else if (cur_ts == TS_LIMIT) state_next = S_DONE;
         end
         S_DONE: begin
            if (!enable) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
   assign pop        = rd_en && !empty_q;
   assign push_ok    = push_req && (!full_q || pop);
   assign drop       = push_req && full_q && !pop;
   assign count_next = count_q + CW'(push_ok) - CW'(pop);

   // FSM, timestamp and baseline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         ts_q    <= '0;
         prev_q  <= '0;
      end else begin
         state_q <= state_next;
         done_q  <= (state_next == S_DONE);
         if (state_q == S_ARM || state_q == S_RUN) ts_q <= cur_ts;
         // The previous sample follows every change, even one that gets dropped.
         if (push_req) prev_q <= ch_data;
      end
   end

   // FIFO bookkeeping and drop counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_next;
         empty_q <= (count_next == '0);
         full_q  <= (count_next == CW'(DEPTH));
         if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   // Record storage. The storage has no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem[wr_ptr] <= {cur_ts, rec_mask, ch_data};
   end

   assign rd_data  = mem[rd_ptr];
   assign rd_empty = empty_q;
   assign full     = full_q;
   assign drop_cnt = drop_q;
   assign done     = done_q;
   assign state    = state_q;

endmodule

// File: tb/tb_port_trace_monitor.sv
// Directed bench for port_trace_monitor. The main instance has DEPTH=4, which
// is enough for the baseline, change, overflow, push/pop and reset cases. A
// second instance has MAX_CYCLES=8 and is used for the run-limit case.
module tb_port_trace_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, rd_en;
   logic [15:0] ch_data;
   logic [41:0] rd_data;
   logic        rd_empty, full, done;
   logic [7:0]  drop_cnt;
   logic [1:0]  state;

   logic        l_enable, l_rd_en;
   logic [15:0] l_ch_data;
   logic [41:0] l_rd_data;
   logic        l_rd_empty, l_full, l_done;
   logic [7:0]  l_drop_cnt;
   logic [1:0]  l_state;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   port_trace_monitor #(.WIDTH(8), .NCH(2), .DEPTH(4), .TS_W(24), .MAX_CYCLES(1000)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ch_data(ch_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_empty(rd_empty), .full(full), .drop_cnt(drop_cnt),
      .done(done), .state(state)
   );

   port_trace_monitor #(.WIDTH(8), .NCH(2), .DEPTH(16), .TS_W(24), .MAX_CYCLES(8)) dut_lim (
      .clk(clk), .reset(reset), .enable(l_enable), .ch_data(l_ch_data), .rd_en(l_rd_en),
      .rd_data(l_rd_data), .rd_empty(l_rd_empty), .full(l_full), .drop_cnt(l_drop_cnt),
      .done(l_done), .state(l_state)
   );

   function automatic logic [41:0] rec(input logic [23:0] ts, input logic [1:0] m,
                                       input logic [15:0] d);
      return {ts, m, d};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are checked and inputs driven on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; rd_en = 1'b0; ch_data = 16'h0000;
      l_enable = 1'b0; l_rd_en = 1'b0; l_ch_data = 16'h0000;
      tick(); tick();
      check("rst_state", 64'(state), 64'd0);
      check("rst_empty", 64'(rd_empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b0; enable = 1'b1; ch_data = 16'h3412;

      // Baseline record
      tick();
      check("arm_state", 64'(state), 64'd1);
      check("arm_empty", 64'(rd_empty), 64'd1);
      tick();
      check("run_state", 64'(state), 64'd2);
      check("base_empty", 64'(rd_empty), 64'd0);
      check("base_rec", 64'(rd_data), 64'(rec(24'd0, 2'b11, 16'h3412)));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("nochg_empty1", 64'(rd_empty), 64'd1);
      tick(); tick(); tick();
      check("nochg_empty4", 64'(rd_empty), 64'd1);
      ch_data = 16'h3413;                       // sampled in the ts=5 cycle
      tick();
      check("chg_empty", 64'(rd_empty), 64'd0);
      check("chg_rec", 64'(rd_data), 64'(rec(24'd5, 2'b01, 16'h3413)));
      rd_en = 1'b1;
      tick();
      check("pop_empty", 64'(rd_empty), 64'd1);
      tick();                                   // a pop on an empty FIFO is ignored
      rd_en = 1'b0;
      check("pop_mt_empty", 64'(rd_empty), 64'd1);
      check("pop_mt_full", 64'(full), 64'd0);
      enable = 1'b0;
      tick();
      check("idle_state", 64'(state), 64'd0);
      enable = 1'b1;
      tick();
      check("rearm_state", 64'(state), 64'd1);

      // Overflow: baseline plus 10 toggles of channel 1
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 3) begin
            check("ovf_full4", 64'(full), 64'd1);
            check("ovf_drop0", 64'(drop_cnt), 64'd0);
         end
         if (i == 4) check("ovf_drop1", 64'(drop_cnt), 64'd1);
         ch_data[15:8] = ch_data[15:8] ^ 8'hFF;
      end
      tick();
      check("ovf_full", 64'(full), 64'd1);
      check("ovf_drop7", 64'(drop_cnt), 64'd7);
      check("ovf_head", 64'(rd_data), 64'(rec(24'd0, 2'b11, 16'h3413)));

      // Push with a same-cycle pop while full
      rd_en = 1'b1;
      ch_data = 16'hCB13;
      tick();
      check("pp_full", 64'(full), 64'd1);
      check("pp_drop", 64'(drop_cnt), 64'd7);
      check("pp_head", 64'(rd_data), 64'(rec(24'd1, 2'b10, 16'hCB13)));
      tick();
      check("drain_h2", 64'(rd_data), 64'(rec(24'd2, 2'b10, 16'h3413)));
      check("drain_full", 64'(full), 64'd0);
      tick();
      check("drain_h3", 64'(rd_data), 64'(rec(24'd3, 2'b10, 16'hCB13)));
      tick();
      check("drain_h11", 64'(rd_data), 64'(rec(24'd11, 2'b10, 16'hCB13)));
      ch_data = 16'h3413;                       // push with a pop on a single record
      tick();
      check("one_empty", 64'(rd_empty), 64'd0);
      check("one_head", 64'(rd_data), 64'(rec(24'd15, 2'b10, 16'h3413)));
      tick();
      rd_en = 1'b0;
      check("one_popped", 64'(rd_empty), 64'd1);

      // Queue three records, then reset mid-run
      ch_data = 16'h3455;
      tick(); ch_data = 16'h3456;
      tick(); ch_data = 16'h3457;
      tick();
      check("q3_empty", 64'(rd_empty), 64'd0);
      check("q3_state", 64'(state), 64'd2);
      check("q3_head", 64'(rd_data), 64'(rec(24'd17, 2'b01, 16'h3455)));
      reset = 1'b1;
      tick();
      check("mid_rst_empty", 64'(rd_empty), 64'd1);
      check("mid_rst_drop", 64'(drop_cnt), 64'd0);
      check("mid_rst_state", 64'(state), 64'd0);
      check("mid_rst_full", 64'(full), 64'd0);
      reset = 1'b0; enable = 1'b0;

      // Run limit: MAX_CYCLES=8
      l_enable = 1'b1; l_ch_data = 16'h0102;
      tick();
      check("lim_arm", 64'(l_state), 64'd1);
      tick();
      check("lim_run", 64'(l_state), 64'd2);
      check("lim_base", 64'(l_rd_data), 64'(rec(24'd0, 2'b11, 16'h0102)));
      for (int i = 0; i < 6; i++) tick();
      check("lim_ts7_done", 64'(l_done), 64'd0);
      check("lim_ts7_state", 64'(l_state), 64'd2);
      l_ch_data = 16'h0103;                     // still recorded, ts=7
      tick();
      check("lim_done", 64'(l_done), 64'd1);
      check("lim_dstate", 64'(l_state), 64'd3);
      l_rd_en = 1'b1;
      l_ch_data = 16'h0104;                     // must not be recorded in DONE
      tick();
      check("lim_rec7", 64'(l_rd_data), 64'(rec(24'd7, 2'b01, 16'h0103)));
      tick();
      l_rd_en = 1'b0;
      check("lim_nodone_rec", 64'(l_rd_empty), 64'd1);
      l_enable = 1'b0;
      tick();
      check("lim_idle", 64'(l_state), 64'd0);
      check("lim_idle_done", 64'(l_done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/port_trace_monitor.md
PORT_TRACE_MONITOR -- requirements
Module: port_trace_monitor

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each monitored channel.
REQ-002 Parameter NCH, default 2, number of monitored channels (e.g. w_output, b_output).
REQ-003 Parameter DEPTH, default 16, trace FIFO entries, power of two, minimum 2.
REQ-004 Parameter TS_W, default 24, timestamp counter width.
REQ-005 Parameter MAX_CYCLES, default 500000, RUN-cycle limit before DONE; 1 <= MAX_CYCLES < 2^TS_W.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  arm/run request; level-sensitive.
REQ-009 ch_data  in  NCH*WIDTH  monitored values; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 rd_en  in  1  pop request for the FIFO head.
REQ-011 rd_data  out  TS_W+NCH+NCH*WIDTH  FIFO head record {timestamp, change_mask, data}; first-word-fall-through.
REQ-012 rd_empty  out  1  FIFO holds no record.
REQ-013 full  out  1  FIFO holds DEPTH records.
REQ-014 drop_cnt  out  8  saturating count of records lost to a full FIFO.
REQ-015 done  out  1  RUN-cycle limit reached.
REQ-016 state  out  2  current FSM state: IDLE=0, ARM=1, RUN=2, DONE=3.

Function
REQ-017 The FSM SHALL move IDLE->ARM on enable=1; ARM->RUN unconditionally after one cycle; RUN->DONE when the timestamp equals MAX_CYCLES-1; RUN->IDLE or DONE->IDLE when enable=0.
REQ-018 In ARM, the block SHALL latch ch_data as the baseline, clear the timestamp to 0, and push one record with change_mask all ones and timestamp 0.
REQ-019 In RUN, the timestamp SHALL increment by 1 per cycle, starting at 1 on the first RUN cycle.
REQ-020 In RUN, each cycle the block SHALL compare ch_data with the previous sample, with bit k of change_mask = 1 iff channel k differs.
REQ-021 When change_mask is nonzero, the block SHALL push {current timestamp, change_mask, ch_data} and update the previous sample.
REQ-022 When the mask is all zeros, the block SHALL push nothing.
REQ-023 Records SHALL enter the FIFO one cycle after the sampled ch_data and SHALL be visible on rd_data with rd_empty=0 in that same cycle.
REQ-024 A pop SHALL occur when rd_en=1 and rd_empty=0; rd_en on empty SHALL be ignored with no state change.
REQ-025 A push arriving while full=1 without a same-cycle pop SHALL be dropped and SHALL increment drop_cnt, saturating at 255.
REQ-026 A push with a same-cycle pop while full SHALL be accepted, leaving full=1.
REQ-027 A simultaneous push and pop on a FIFO holding one record SHALL leave one record (the new one) at the head.
REQ-028 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL use a separate count or an extra pointer bit so that full and empty are unambiguous.
REQ-029 In DONE and IDLE, no comparison or push SHALL occur and the timestamp SHALL hold; the FIFO SHALL remain readable.
REQ-030 done SHALL be 1 exactly while state=DONE.
REQ-031 Re-entering ARM from IDLE SHALL NOT clear the FIFO or drop_cnt; only reset clears them.

Reset
REQ-032 With reset=1 at a rising edge, state SHALL become IDLE.
REQ-033 Reset SHALL clear the FIFO, giving rd_empty=1 and full=0.
REQ-034 Reset SHALL clear drop_cnt, the timestamp and the previous sample to 0, and deassert done.
REQ-035 Reset SHALL take priority over enable, rd_en and any pending push or pop, including in the middle of a RUN.
REQ-036 rd_data SHALL be don't-care while rd_empty=1.

Verification
REQ-037 Baseline: with WIDTH=8 and NCH=2, reset for 2 cycles, then enable=1 with ch_data=16'h3412 -> one record {ts=0, mask=2'b11, data=16'h3412}, state sequence IDLE->ARM->RUN.
REQ-038 Change capture: in RUN, change channel 0 only, to 8'h13, at ts=5 -> record {5, 2'b01, 16'h3413}; unchanged cycles produce no records.
REQ-039 Overflow: with DEPTH=4 and rd_en=0, toggle channel 1 every cycle for 10 cycles -> full=1 after 4 records, drop_cnt=7 including the baseline, head still the baseline record.
REQ-040 Push/pop on full: with the FIFO full, apply rd_en=1 together with a change -> full stays 1, drop_cnt unchanged, the next head is the 2nd-oldest record.
REQ-041 Limit: with MAX_CYCLES=8 -> done=1 in the cycle after ts=7; a later change is not recorded; enable=0 -> IDLE with done=0.
REQ-042 Reset mid-run: assert reset with 3 records queued -> next cycle rd_empty=1, drop_cnt=0, state=IDLE.
